// File: rtl/bit_string_serializer.sv
// Parallel-to-serial bit string source: accepts a word over valid/ready and
// emits it MSB first on A. Optional macro SER_EXP_COUNT_EN adds exp_count.
module bit_string_serializer #(
  parameter int   WIDTH      = 16,
  parameter int   LEN_W      = 5,
  parameter logic IDLE_LEVEL = 1'b0
`ifdef SER_EXP_COUNT_EN
  , parameter int EXP_W      = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  output logic             A,
  output logic             a_valid,
  output logic             last,
  output logic             busy
`ifdef SER_EXP_COUNT_EN
  , output logic [EXP_W-1:0] exp_count
`endif
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             a_q, a_d;
  logic             a_valid_q, a_valid_d;
  logic             last_q, last_d;
  logic             accept;
  logic [LEN_W-1:0] len_eff;

`ifdef SER_EXP_COUNT_EN
  logic [EXP_W-1:0] exp_count_q, exp_count_d;
`endif

  // A new word can enter while idle or in the cycle its predecessor ends.
  assign load_ready = ~rst & ((state_q == IDLE) | last_q);
  assign accept     = load_valid & load_ready;

  // Zero selects a full word; out-of-range lengths are clamped to WIDTH.
  assign len_eff = ((load_len == '0) || (load_len > LEN_W'(WIDTH))) ?
                   LEN_W'(WIDTH) : load_len;

  always_comb begin
    // NOTE: every _d takes its held value first, so no path leaves it
    // unassigned and no latch is inferred.
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    a_valid_d = a_valid_q;
    last_d    = last_q;

    if (accept) begin
      // cnt holds the number of bits still to follow the one now on A.
      state_d   = SHIFT;
      a_d       = load_data[WIDTH-1];
      shreg_d   = load_data << 1;
      cnt_d     = len_eff - LEN_W'(1);
      a_valid_d = 1'b1;
      last_d    = (len_eff == LEN_W'(1));
    end else if (state_q == SHIFT) begin
      if (last_q) begin
        state_d   = IDLE;
        a_d       = IDLE_LEVEL;
        a_valid_d = 1'b0;
        last_d    = 1'b0;
      end else begin
        a_d     = shreg_q[WIDTH-1];
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q - LEN_W'(1);
        last_d  = (cnt_q == LEN_W'(1));
      end
    end
  end

`ifdef SER_EXP_COUNT_EN
  // Counts rising edges of the registered A, saturating at all-ones.
  always_comb begin
    exp_count_d = exp_count_q;
    if (a_d && !a_q && (exp_count_q != '1))
      exp_count_d = exp_count_q + EXP_W'(1);
  end
`endif

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      a_q         <= IDLE_LEVEL;
      a_valid_q   <= 1'b0;
      last_q      <= 1'b0;
`ifdef SER_EXP_COUNT_EN
      exp_count_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      a_valid_q   <= a_valid_d;
      last_q      <= last_d;
`ifdef SER_EXP_COUNT_EN
      exp_count_q <= exp_count_d;
`endif
    end
  end

  assign A       = a_q;
  assign a_valid = a_valid_q;
  assign last    = last_q;
  assign busy    = a_valid_q;
`ifdef SER_EXP_COUNT_EN
  assign exp_count = exp_count_q;
`endif

endmodule

// File: tb/tb_bit_string_serializer.sv
// Scoreboard bench for bit_string_serializer: the driver queues the expected
// bit stream of each accepted word; a negedge monitor pops and compares.
module tb_bit_string_serializer;
  localparam int   W    = 16;
  localparam int   LW   = 5;
  localparam logic IDLE = 1'b0;

  typedef struct {
    logic b;
    logic lst;
  } exp_bit_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [W-1:0]  load_data = '0;
  logic [LW-1:0] load_len = '0;
  logic          A, a_valid, last, busy;
`ifdef SER_EXP_COUNT_EN
  logic [7:0]    exp_count;
  int            model_cnt = 0;
  logic          model_prev = IDLE;
`endif

  exp_bit_t sb[$];
  int       checks = 0;
  int       failures = 0;

  bit_string_serializer dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_len(load_len), .A(A), .a_valid(a_valid),
    .last(last), .busy(busy)
`ifdef SER_EXP_COUNT_EN
    , .exp_count(exp_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Offer a word; hold it until the serializer accepts, then queue its bits.
  task automatic send_word(input logic [W-1:0] d, input logic [LW-1:0] len);
    int n;
    int waited;
    bit ok;
    n = (len == 0 || int'(len) > W) ? W : int'(len);
    load_data  = d;
    load_len   = len;
    load_valid = 1'b1;
    waited     = 0;
    ok         = 1'b0;
    while (waited < 100) begin
      @(negedge clk);
      if (load_ready) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (ok)
      for (int i = 0; i < n; i++) sb.push_back('{b: d[W-1-i], lst: (i == n - 1)});
    load_valid = 1'b0;
    load_data  = W'($urandom);
    load_len   = LW'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      load_data = W'($urandom);
      load_len  = LW'($urandom);
    end
  endtask

  // Monitor: expected outputs come only from the scoreboard queue.
  initial begin
    exp_bit_t e;
    logic exp_v, exp_a, exp_l;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_v = 1'b0; exp_a = IDLE; exp_l = 1'b0;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          exp_v = 1'b1; exp_a = e.b; exp_l = e.lst;
        end
        check("a_valid", 32'(a_valid), 32'(exp_v));
        check("A", 32'(A), 32'(exp_a));
        check("last", 32'(last), 32'(exp_l));
        check("busy", 32'(busy), 32'(exp_v));
        check("load_ready", 32'(load_ready), 32'(sb.size() == 0));
`ifdef SER_EXP_COUNT_EN
        if (exp_a && !model_prev && model_cnt < 255) model_cnt++;
        model_prev = exp_a;
        check("exp_count", 32'(exp_count), 32'(model_cnt));
`endif
      end
    end
  end

  initial begin
    int gap;
    int waited;
    #2;
    check("rst_A", 32'(A), 32'(IDLE));
    check("rst_a_valid", 32'(a_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    send_word(16'h4000, 5'd16);
    idle_cycles(18);
    send_word(16'hA000, 5'd4);
    idle_cycles(7);
    send_word(16'hF000, 5'd4);
    send_word(16'h0000, 5'd2);
    idle_cycles(4);
    send_word(16'h8001, 5'd0);
    idle_cycles(18);

    // Abort a word mid-stream with an asynchronous reset.
    send_word(16'hFFFF, 5'd16);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_A", 32'(A), 32'(IDLE));
    check("abort_a_valid", 32'(a_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_load_ready", 32'(load_ready), 32'd0);
    sb.delete();
`ifdef SER_EXP_COUNT_EN
    model_cnt  = 0;
    model_prev = IDLE;
`endif
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check("release_load_ready", 32'(load_ready), 32'd1);
    send_word(16'h5A5A, 5'd7);
    idle_cycles(2);

    // Randomized words with random gaps (gap 0 exercises back-to-back).
    for (int k = 0; k < 80; k++) begin
      send_word(W'($urandom), LW'($urandom_range(0, 16)));
      gap = $urandom_range(0, 3);
      if (gap != 0) idle_cycles(gap);
    end

    waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    idle_cycles(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
